// File: rtl/serial_parity_deserializer.sv
// serial_parity_deserializer
// Collects W data bits (LSB first) plus one parity bit from a one-bit-per-cycle
// stream. Emits the assembled word with a parity check result as a registered
// one-cycle pulse. An in_start bit restarts framing, and any partial frame is
// discarded with an out_abort pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   in_valid       in_bit / in_start are meaningful this cycle
//   in_bit         serial bit (data LSB first, then parity)
//   in_start       marks this bit as data bit 0 of a new frame
//   out_valid      one-cycle pulse when a frame completes
//   out_data       last complete frame's data word (held)
//   out_parity_err parity mismatch for out_data (held)
//   out_abort      one-cycle pulse when a partial frame is discarded
module serial_parity_deserializer #(
  parameter int unsigned W          = 8,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_start,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_parity_err,
  output logic         out_abort
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [0:0] ST_DATA   = 1'b0;
  localparam logic [0:0] ST_PARITY = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         acc_q, acc_d;
  logic [W-1:0] sh_q, sh_d;
  logic         valid_d, abort_d, perr_d;
  logic [W-1:0] data_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_DATA;
      cnt_q          <= '0;
      acc_q          <= 1'b0;
      sh_q           <= '0;
      out_valid      <= 1'b0;
      out_abort      <= 1'b0;
      out_data       <= '0;
      out_parity_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      sh_q           <= sh_d;
      out_valid      <= valid_d;
      out_abort      <= abort_d;
      out_data       <= data_d;
      out_parity_err <= perr_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
    data_d  = out_data;
    perr_d  = out_parity_err;

    if (in_valid) begin
      if (in_start) begin
        // Start always wins; anything already collected is dropped
        abort_d  = (state_q == ST_PARITY) || (cnt_q != '0);
        state_d  = ST_DATA;
        sh_d[0]  = in_bit;
        acc_d    = in_bit;
        cnt_d    = CW'(1);
      end else if (state_q == ST_DATA) begin
        sh_d[cnt_q] = in_bit;
        acc_d       = acc_q ^ in_bit;
        if (cnt_q == CW'(W - 1)) begin
          state_d = ST_PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        data_d  = sh_q;
        perr_d  = acc_q ^ in_bit ^ 1'(ODD_PARITY);
        valid_d = 1'b1;
        acc_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_DATA;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_deserializer.sv
// Self-checking bench for serial_parity_deserializer (W=8, even and odd parity).
module tb_serial_parity_deserializer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_bit, in_start;
  logic         out_valid, out_parity_err, out_abort;
  logic [W-1:0] out_data;
  logic         o_valid, o_parity_err, o_abort;
  logic [W-1:0] o_data;

  serial_parity_deserializer #(.W(W), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_start(in_start),
    .out_valid(out_valid), .out_data(out_data), .out_parity_err(out_parity_err),
    .out_abort(out_abort));

  serial_parity_deserializer #(.W(W), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_start(in_start),
    .out_valid(o_valid), .out_data(o_data), .out_parity_err(o_parity_err),
    .out_abort(o_abort));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level reference model for the even-parity instance
  bit           mq[$];
  logic [W-1:0] exp_data_q[$];
  logic         exp_perr_q[$];
  int           m_aborts = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else if (in_valid) begin
      if (in_start) begin
        if (mq.size() != 0) m_aborts++;
        mq.delete();
      end
      mq.push_back(in_bit);
      if (mq.size() == W + 1) begin
        logic [W-1:0] word;
        int ones;
        word = '0;
        ones = 0;
        for (int i = 0; i < W; i++) begin
          word = word | (W'(mq[i]) << i);
          ones += int'(mq[i]);
        end
        ones += int'(mq[W]);
        exp_data_q.push_back(word);
        exp_perr_q.push_back((ones % 2) != 0);
        mq.delete();
      end
    end
  end

  // Observation of the even-parity instance
  logic [W-1:0] obs_data_q[$];
  logic         obs_perr_q[$];
  int           vcyc_q[$];
  int           valid_cnt = 0;
  int           abort_cnt = 0;
  int           last_abort_cyc = -1;

  always @(negedge clk) begin
    if (out_valid) begin
      obs_data_q.push_back(out_data);
      obs_perr_q.push_back(out_parity_err);
      vcyc_q.push_back(cyc);
      valid_cnt++;
    end
    if (out_abort) begin
      abort_cnt++;
      last_abort_cyc = cyc;
    end
  end

  task automatic drive(input logic b, input logic s, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_start = 1'($urandom);
      in_bit   = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
    in_start = s;
    if (s) last_start_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_start = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic par, input int maxgap);
    for (int i = 0; i < W; i++)
      drive(word[i], i == 0, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    drive(par, 1'b0, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_abort, out_parity_err, out_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b a=%b e=%b d=%h want 0", out_valid, out_abort, out_parity_err, out_data);
    end
    checks++;
    if ({o_valid, o_abort, o_parity_err, o_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_odd got v=%b a=%b e=%b d=%h want 0", o_valid, o_abort, o_parity_err, o_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_even();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 0);
    idle(2);
    checks++;
    if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL even_ok_pulses got %0d want 1", valid_cnt - v0); end
    checks++;
    if (out_data !== 8'hA5) begin failures++; $display("FAIL even_ok_data got %h want a5", out_data); end
    checks++;
    if (out_parity_err !== 1'b0) begin failures++; $display("FAIL even_ok_err got %b want 0", out_parity_err); end
    send_frame(8'hA5, 1'b1, 0);
    idle(2);
    checks++;
    if (out_data !== 8'hA5) begin failures++; $display("FAIL even_bad_data got %h want a5", out_data); end
    checks++;
    if (out_parity_err !== 1'b1) begin failures++; $display("FAIL even_bad_err got %b want 1", out_parity_err); end
  endtask

  task automatic test_odd();
    send_frame(8'h01, 1'b0, 0);
    idle(2);
    checks++;
    if (o_data !== 8'h01) begin failures++; $display("FAIL odd_01_data got %h want 01", o_data); end
    checks++;
    if (o_parity_err !== 1'b0) begin failures++; $display("FAIL odd_01_err got %b want 0", o_parity_err); end
    send_frame(8'h03, 1'b0, 0);
    idle(2);
    checks++;
    if (o_data !== 8'h03) begin failures++; $display("FAIL odd_03_data got %h want 03", o_data); end
    checks++;
    if (o_parity_err !== 1'b1) begin failures++; $display("FAIL odd_03_err got %b want 1", o_parity_err); end
  endtask

  task automatic test_gaps();
    int v0;
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, 5);
    idle(2);
    checks++;
    if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL gaps_pulses got %0d want 1", valid_cnt - v0); end
    checks++;
    if (out_data !== 8'h3C || out_parity_err !== 1'b0) begin
      failures++; $display("FAIL gaps_result got d=%h e=%b want d=3c e=0", out_data, out_parity_err);
    end
    idle(7);
    checks++;
    if (out_data !== 8'h3C || out_valid !== 1'b0) begin
      failures++; $display("FAIL gaps_hold got d=%h v=%b want d=3c v=0", out_data, out_valid);
    end
  endtask

  task automatic test_abort();
    int v0, a0;
    logic [W-1:0] junk;
    v0 = valid_cnt; a0 = abort_cnt;
    junk = W'($urandom);
    for (int i = 0; i < 5; i++) drive(junk[i], i == 0, 0);
    send_frame(8'h81, 1'b0, 0);
    idle(2);
    checks++;
    if (abort_cnt - a0 !== 1) begin failures++; $display("FAIL abort_pulses got %0d want 1", abort_cnt - a0); end
    checks++;
    if (last_abort_cyc !== last_start_cyc) begin
      failures++; $display("FAIL abort_timing got cycle %0d want %0d", last_abort_cyc, last_start_cyc);
    end
    checks++;
    if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL abort_valids got %0d want 1", valid_cnt - v0); end
    checks++;
    if (out_data !== 8'h81 || out_parity_err !== 1'b0) begin
      failures++; $display("FAIL abort_result got d=%h e=%b want d=81 e=0", out_data, out_parity_err);
    end
  endtask

  task automatic test_back_to_back();
    int v0, n0;
    logic [W-1:0] wd[3];
    logic         we[3];
    wd[0] = 8'hFF; wd[1] = 8'h00; wd[2] = 8'h0F;
    we[0] = 1'b0;  we[1] = 1'b0;  we[2] = 1'b1;
    v0 = valid_cnt; n0 = vcyc_q.size();
    send_frame(8'hFF, 1'b0, 0);
    send_frame(8'h00, 1'b0, 0);
    send_frame(8'h0F, 1'b1, 0);
    idle(2);
    checks++;
    if (valid_cnt - v0 !== 3) begin
      failures++; $display("FAIL b2b_pulses got %0d want 3", valid_cnt - v0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_data_q[n0+i] !== wd[i] || obs_perr_q[n0+i] !== we[i]) begin
          failures++;
          $display("FAIL b2b_frame%0d got d=%h e=%b want d=%h e=%b", i, obs_data_q[n0+i], obs_perr_q[n0+i], wd[i], we[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (vcyc_q[n0+i] - vcyc_q[n0+i-1] !== 9) begin
          failures++; $display("FAIL b2b_spacing%0d got %0d want 9", i, vcyc_q[n0+i] - vcyc_q[n0+i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int v0, a0;
    v0 = valid_cnt; a0 = abort_cnt;
    for (int i = 0; i < 4; i++) drive(1'($urandom), i == 0, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_start = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_abort, out_parity_err, out_data} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got v=%b a=%b e=%b d=%h want 0", out_valid, out_abort, out_parity_err, out_data);
    end
    rst = 1'b0; in_valid = 1'b0; in_start = 1'b0;
    send_frame(8'h5A, 1'b0, 0);
    idle(2);
    checks++;
    if (abort_cnt !== a0) begin failures++; $display("FAIL midreset_abort got %0d aborts want 0", abort_cnt - a0); end
    checks++;
    if (valid_cnt - v0 !== 1 || out_data !== 8'h5A || out_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_result got n=%0d d=%h e=%b want n=1 d=5a e=0", valid_cnt - v0, out_data, out_parity_err);
    end
  endtask

  task automatic test_random();
    int a0, ma0;
    exp_data_q.delete(); exp_perr_q.delete();
    obs_data_q.delete(); obs_perr_q.delete();
    a0 = abort_cnt; ma0 = m_aborts;
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(3, 0) == 0) begin
        int k;
        k = int'($urandom_range(W, 1));
        for (int i = 0; i < k; i++) drive(1'($urandom), i == 0, int'($urandom_range(2, 0)));
      end
      send_frame(W'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
    end
    idle(3);
    checks++;
    if (obs_data_q.size() !== exp_data_q.size()) begin
      failures++; $display("FAIL random_count got %0d frames want %0d", obs_data_q.size(), exp_data_q.size());
    end else begin
      for (int i = 0; i < exp_data_q.size(); i++) begin
        checks++;
        if (obs_data_q[i] !== exp_data_q[i] || obs_perr_q[i] !== exp_perr_q[i]) begin
          failures++;
          $display("FAIL random_frame%0d got d=%h e=%b want d=%h e=%b", i, obs_data_q[i], obs_perr_q[i], exp_data_q[i], exp_perr_q[i]);
        end
      end
    end
    checks++;
    if (abort_cnt - a0 !== m_aborts - ma0) begin
      failures++; $display("FAIL random_aborts got %0d want %0d", abort_cnt - a0, m_aborts - ma0);
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
